// File: rtl/nts_tx_buffer_pkg.sv
// nts_tx_buffer_pkg
// Shared constants for the NTS transmit path.
// Contents:
//   - Write-side and read-side FSM state encodings of the two-slot frame buffer.
//   - Byte-mask constants.
//   - Mask classification helpers. A legal mask is 0xFF or a contiguous
//     low-order run (0x01, 0x03 ... 0x7F).
package nts_tx_buffer_pkg;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_DATA = 2'd1,
        W_DROP = 2'd2
    } wr_state_t;

    typedef enum logic {
        R_IDLE   = 1'b0,
        R_STREAM = 1'b1
    } rd_state_t;

    localparam logic [7:0] MASK_FULL = 8'hFF;
    localparam logic [7:0] MASK_NONE = 8'h00;

    // A contiguous low-order run m has no bit in common with m+1.
    function automatic logic mask_legal(input logic [7:0] mask);
        logic [7:0] inc;
        inc = mask + 8'd1;
        return (mask != MASK_NONE) && ((mask & inc) == 8'd0);
    endfunction

    // A legal mask that is not full closes the frame on that word.
    function automatic logic mask_partial(input logic [7:0] mask);
        return mask_legal(mask) && (mask != MASK_FULL);
    endfunction

endpackage

// File: rtl/nts_tx_buffer_ram.sv
// nts_tx_buffer_ram
// Simple dual-port frame storage: one write port, one read port with a
// registered output (one cycle of read latency). The slot index is the
// address MSB.
// Ports:
//   clk                      clock
//   wr_en, wr_addr, wr_data  write port
//   rd_en, rd_addr           read request
//   rd_data                  read data, valid the cycle after rd_en
module nts_tx_buffer_ram
    import nts_tx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/nts_tx_buffer.sv
// nts_tx_buffer
// Two-slot (ping-pong) frame buffer between the NTS transmit interface and a
// streaming MAC transmit port. Complete frames are stored, then replayed at
// one word per cycle; malformed or oversized frames are discarded so the MAC
// never sees a partial frame.
// Ports:
//   i_clk, i_areset_n         clock, asynchronous active-low reset
//   i_tx_start / o_tx_ack     frame request (level) / one-cycle grant
//   i_tx_data_valid, i_tx_data  byte mask and frame word
//   o_mac_tvalid, i_mac_tready, o_mac_tdata, o_mac_tkeep, o_mac_tlast
//                             MAC stream with backpressure
//   o_frames_sent, o_frames_dropped  wrapping frame counters
module nts_tx_buffer
    import nts_tx_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH     = 8,
    parameter int MAC_DATA_WIDTH = 64
) (
    input  logic                      i_clk,
    input  logic                      i_areset_n,
    input  logic                      i_tx_start,
    output logic                      o_tx_ack,
    input  logic [7:0]                i_tx_data_valid,
    input  logic [MAC_DATA_WIDTH-1:0] i_tx_data,
    output logic                      o_mac_tvalid,
    input  logic                      i_mac_tready,
    output logic [MAC_DATA_WIDTH-1:0] o_mac_tdata,
    output logic [7:0]                o_mac_tkeep,
    output logic                      o_mac_tlast,
    output logic [31:0]               o_frames_sent,
    output logic [31:0]               o_frames_dropped
);

    localparam logic [ADDR_WIDTH:0] SLOT_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] PTR_ONE    = {{ADDR_WIDTH{1'b0}}, 1'b1};

    // Write side and per-slot metadata
    wr_state_t           wr_state;
    logic                wslot;
    logic [ADDR_WIDTH:0] wptr;
    logic [1:0]          slot_full;
    logic [ADDR_WIDTH:0] slot_cnt  [2];
    logic [7:0]          slot_mask [2];

    // Read side
    rd_state_t           rd_state;
    logic                rslot;
    logic [ADDR_WIDTH:0] rptr;
    logic                ram_q_valid;
    logic                ram_q_last;
    logic [7:0]          ram_q_keep;
    logic [MAC_DATA_WIDTH-1:0] ram_rd_data;

    // Two-entry output skid buffer; its head drives the MAC port.
    logic [MAC_DATA_WIDTH-1:0] fifo_data [2];
    logic [7:0]                fifo_keep [2];
    logic [1:0]                fifo_last;
    logic                      fifo_wr_idx;
    logic                      fifo_rd_idx;
    logic [1:0]                fifo_cnt;

    logic       mask_ok, mask_end, word_fits, ram_wr_en;
    logic       xfer, rd_free, slot_avail, rd_more, rd_last_word, rd_issue;
    logic [2:0] rd_occ;

    assign mask_ok   = mask_legal(i_tx_data_valid);
    assign mask_end  = mask_partial(i_tx_data_valid);
    assign word_fits = (wptr != SLOT_WORDS);
    assign ram_wr_en = (wr_state == W_DATA) && mask_ok && word_fits;

    assign xfer    = o_mac_tvalid && i_mac_tready;
    assign rd_free = xfer && fifo_last[fifo_rd_idx];
    // A slot freed this cycle can be granted in the same cycle.
    assign slot_avail = !slot_full[wslot] || (rd_free && (rslot == wslot));

    // Occupancy after this cycle counting the read in flight; a new read may
    // be issued only if its data is guaranteed a skid entry.
    assign rd_occ       = {1'b0, fifo_cnt} + {2'b00, ram_q_valid} - {2'b00, xfer};
    assign rd_more      = (rptr != slot_cnt[rslot]);
    assign rd_last_word = ((rptr + PTR_ONE) == slot_cnt[rslot]);
    assign rd_issue     = (rd_state == R_STREAM) && rd_more && (rd_occ < 3'd2);

    assign o_mac_tvalid = (fifo_cnt != 2'd0);
    assign o_mac_tdata  = fifo_data[fifo_rd_idx];
    assign o_mac_tkeep  = fifo_keep[fifo_rd_idx];
    assign o_mac_tlast  = fifo_last[fifo_rd_idx];

    nts_tx_buffer_ram #(
        .ADDR_WIDTH (ADDR_WIDTH + 1),
        .DATA_WIDTH (MAC_DATA_WIDTH)
    ) u_ram (
        .clk     (i_clk),
        .wr_en   (ram_wr_en),
        .wr_addr ({wslot, wptr[ADDR_WIDTH-1:0]}),
        .wr_data (i_tx_data),
        .rd_en   (rd_issue),
        .rd_addr ({rslot, rptr[ADDR_WIDTH-1:0]}),
        .rd_data (ram_rd_data)
    );

    // Write FSM: accepts frames and owns the slot metadata.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            wr_state         <= W_IDLE;
            wslot            <= 1'b0;
            wptr             <= '0;
            slot_full        <= 2'b00;
            slot_cnt[0]      <= '0;
            slot_cnt[1]      <= '0;
            slot_mask[0]     <= '0;
            slot_mask[1]     <= '0;
            o_tx_ack         <= 1'b0;
            o_frames_dropped <= '0;
        end else begin
            o_tx_ack <= 1'b0;
            if (rd_free) begin
                slot_full[rslot] <= 1'b0;
            end
            case (wr_state)
                W_IDLE: begin
                    if (i_tx_start && slot_avail) begin
                        o_tx_ack <= 1'b1;
                        wptr     <= '0;
                        wr_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (i_tx_data_valid == MASK_NONE) begin
                        // Empty mask closes a frame of full words; before the
                        // first word it is just idle.
                        if (wptr != '0) begin
                            slot_full[wslot] <= 1'b1;
                            slot_cnt[wslot]  <= wptr;
                            slot_mask[wslot] <= MASK_FULL;
                            wslot            <= ~wslot;
                            wr_state         <= W_IDLE;
                        end
                    end else if (!mask_ok || !word_fits) begin
                        if (mask_end) begin
                            o_frames_dropped <= o_frames_dropped + 32'd1;
                            wr_state         <= W_IDLE;
                        end else begin
                            wr_state <= W_DROP;
                        end
                    end else begin
                        wptr <= wptr + PTR_ONE;
                        if (mask_end) begin
                            slot_full[wslot] <= 1'b1;
                            slot_cnt[wslot]  <= wptr + PTR_ONE;
                            slot_mask[wslot] <= i_tx_data_valid;
                            wslot            <= ~wslot;
                            wr_state         <= W_IDLE;
                        end
                    end
                end
                W_DROP: begin
                    if ((i_tx_data_valid == MASK_NONE) || mask_end) begin
                        o_frames_dropped <= o_frames_dropped + 32'd1;
                        wr_state         <= W_IDLE;
                    end
                end
                default: wr_state <= W_IDLE;
            endcase
        end
    end

    // Read FSM, RAM output stage and skid buffer.
    always_ff @(posedge i_clk or negedge i_areset_n) begin
        if (!i_areset_n) begin
            rd_state      <= R_IDLE;
            rslot         <= 1'b0;
            rptr          <= '0;
            ram_q_valid   <= 1'b0;
            ram_q_keep    <= '0;
            ram_q_last    <= 1'b0;
            fifo_data[0]  <= '0;
            fifo_data[1]  <= '0;
            fifo_keep[0]  <= '0;
            fifo_keep[1]  <= '0;
            fifo_last     <= 2'b00;
            fifo_wr_idx   <= 1'b0;
            fifo_rd_idx   <= 1'b0;
            fifo_cnt      <= 2'd0;
            o_frames_sent <= '0;
        end else begin
            // Stage: RAM read issue; word tags travel with the read.
            ram_q_valid <= rd_issue;
            ram_q_keep  <= rd_last_word ? slot_mask[rslot] : MASK_FULL;
            ram_q_last  <= rd_last_word;
            case (rd_state)
                R_IDLE: begin
                    if (slot_full[rslot]) begin
                        rptr     <= '0;
                        rd_state <= R_STREAM;
                    end
                end
                R_STREAM: begin
                    if (rd_issue) begin
                        rptr <= rptr + PTR_ONE;
                    end
                    if (rd_free) begin
                        rslot         <= ~rslot;
                        o_frames_sent <= o_frames_sent + 32'd1;
                        rd_state      <= R_IDLE;
                    end
                end
                default: rd_state <= R_IDLE;
            endcase

            // Stage: RAM data into skid buffer; head pops on transfer.
            if (ram_q_valid) begin
                fifo_data[fifo_wr_idx] <= ram_rd_data;
                fifo_keep[fifo_wr_idx] <= ram_q_keep;
                fifo_last[fifo_wr_idx] <= ram_q_last;
                fifo_wr_idx            <= ~fifo_wr_idx;
            end
            if (xfer) begin
                fifo_rd_idx <= ~fifo_rd_idx;
            end
            fifo_cnt <= fifo_cnt + {1'b0, ram_q_valid} - {1'b0, xfer};
        end
    end

endmodule

// File: doc/nts_tx_buffer.md
# nts_tx_buffer

Two-slot frame buffer between the NTS top-level transmit interface (64-bit words with start/ack handshake and per-byte valid mask) and a streaming MAC transmit port with valid/ready backpressure. It accepts complete frames from the extractor path and stores them in ping-pong slots. It replays each frame to the MAC at one word per cycle, discarding malformed or oversized frames so that the MAC never sees a partial frame.

## Interface
Parameters:
- ADDR_WIDTH, 8, log2 of words per slot (256 words = 2048 bytes per slot)
- MAC_DATA_WIDTH, 64, word width; only 64 is supported

Ports:
- i_clk  in  1  sole clock
- i_areset_n  in  1  asynchronous, active-low reset
- i_tx_start  in  1  producer requests a frame; level, held until o_tx_ack
- o_tx_ack  out  1  one-cycle pulse granting the frame
- i_tx_data_valid  in  8  byte-valid mask for i_tx_data
- i_tx_data  in  64  frame word
- o_mac_tvalid  out  1  output word valid
- i_mac_tready  in  1  MAC accepts word
- o_mac_tdata  out  64  output word
- o_mac_tkeep  out  8  byte mask; 0xFF except on the last word
- o_mac_tlast  out  1  final word of frame
- o_frames_sent  out  32  count of frames completed on MAC side (wraps)
- o_frames_dropped  out  32  count of frames discarded (wraps)

## Operation
- Mask legality: 0xFF, or a contiguous low-order mask (0x01, 0x03 … 0x7F). Any other nonzero value is illegal.
- Write FSM states:
  - W_IDLE: if i_tx_start and a slot is free, pulse o_tx_ack and go to W_DATA. Otherwise stay and do not ack.
  - W_DATA: each cycle with a nonzero mask writes the word to slot[wslot][wptr] and increments wptr. The frame ends on a word with a partial mask (that word is last), or on a 0x00 mask after at least one word (previous word is last, mask 0xFF). A 0x00 mask before any word is ignored.
  - On end: store word count and last mask, mark slot full, toggle wslot, go to W_IDLE.
  - W_DROP: entered on an illegal mask, or on a word arriving when wptr == 2^ADDR_WIDTH. Swallow words until 0x00 mask or a partial mask. Increment o_frames_dropped once. The slot stays free. Go to W_IDLE.
- Read FSM states:
  - R_IDLE: when slot[rslot] is full, issue RAM reads and go to R_STREAM.
  - R_STREAM: present words in order. A word advances only when o_mac_tvalid && i_mac_tready. The last word carries the stored mask and o_mac_tlast=1. On its transfer, free the slot, toggle rslot, increment o_frames_sent, and go to R_IDLE.
- Slots are consumed strictly in the order written.
- Reset mid-frame, on either side, discards all buffered data.

## Timing
- Reset values: o_tx_ack=0, o_mac_tvalid=0, o_mac_tdata=0, o_mac_tkeep=0, o_mac_tlast=0, both counters 0, both slots free, wslot=rslot=0.
- i_tx_start high in cycle N (FSM idle, slot free) -> o_tx_ack high in cycle N+1 only.
- First data word is sampled at cycle N+2. One word per cycle; gaps are not allowed within a frame.
- Commit happens on the cycle after the last word. o_mac_tvalid rises no later than 3 cycles after commit (registered RAM read plus output register).
- Sustained output of 1 word per cycle while i_mac_tready=1. A 2-entry skid/prefetch stage guarantees no bubbles under any tready pattern.
- o_mac_tdata, o_mac_tkeep and o_mac_tlast are stable while o_mac_tvalid=1 and i_mac_tready=0.
- Both slots full: start is not acked until the read side frees a slot. A free and a new start in the same cycle grant the ack in the next cycle.
- The slot being read is never writable; simultaneous write-commit and read-free of different slots are both honoured.
- Counters wrap 0xFFFF_FFFF -> 0.

## Structure
- Shared constants file: write/read FSM state encodings, MASK_FULL=8'hFF, and a legal-mask function (contiguous low-order check) reused by other TX-path blocks.
- Sub-module nts_tx_buffer_ram: simple dual-port, depth 2^(ADDR_WIDTH+1) x 64. One write port, one read port with registered output. The slot index is the address MSB.
- Per-slot metadata (word count, last mask, full flag) is held in flops, not RAM.

## Test plan
- Single 60-byte frame: 7 words 0xFF then 0x0F -> ack 1 cycle after start; MAC sees 8 words, tlast and tkeep=0x0F on word 8; frames_sent=1.
- Frame ending on full word followed by 0x00 mask (8 words) -> tkeep=0xFF on word 8 with tlast; no extra word.
- Two back-to-back frames while tready=0, then a third start -> third start not acked until the first frame's last word transfers; then ack next cycle; order preserved.
- Illegal mask 0x5A mid-frame -> frame not emitted, frames_dropped=1, next legal frame passes intact.
- Oversize frame of 257 full words (ADDR_WIDTH=8) -> dropped, frames_dropped increments, slot stays free.
- Random tready toggling during a 200-word frame -> bytes identical, no duplicates or bubbles while tready=1; i_areset_n pulsed mid-stream -> all outputs 0 next edge and buffers empty.
